// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared constants and types for the pipeline stall/flush controller:
// hazard codes, controller FSM states and the scoreboard slot layout.
package pipe_stall_ctrl_pkg;

  localparam logic [1:0] PAUSE_NO = 2'b00;
  localparam logic [1:0] PAUSE_RS = 2'b01;
  localparam logic [1:0] PAUSE_RT = 2'b10;

  typedef enum logic {
    STALL_RUN      = 1'b0,
    STALL_MEM_WAIT = 1'b1
  } stall_state_t;

  // How the scoreboard moves this cycle.
  typedef enum logic [1:0] {
    SB_HOLD    = 2'd0,
    SB_BUBBLE  = 2'd1,
    SB_ADVANCE = 2'd2
  } sb_op_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] wreg;
  } sb_slot_t;

  function automatic logic slot_hit(input sb_slot_t s, input logic [4:0] r);
    return s.valid && (s.wreg == r);
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_hazard_scoreboard.sv
// Two-slot write scoreboard (EX, MEM) with source-register hit detection
// and generation of the hazard code seen by the ID stage.
module hazard_scoreboard
  import pipe_stall_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  sb_op_t     sb_op,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_rs_used,
  input  logic       id_rt_used,
  input  logic       id_reg_we,
  input  logic [4:0] id_wreg,
  output logic [1:0] pause_code
);

  // slots[0] = EX, slots[1] = MEM
  sb_slot_t [1:0] slots;
  sb_slot_t       incoming;
  logic     [1:0] rs_match;
  logic     [1:0] rt_match;
  logic           rs_hit;
  logic           rt_hit;

  assign incoming.valid = id_valid && id_reg_we && (id_wreg != 5'd0);
  assign incoming.wreg  = id_wreg;

  for (genvar gi = 0; gi < 2; gi++) begin : g_match
    assign rs_match[gi] = slot_hit(slots[gi], id_rs);
    assign rt_match[gi] = slot_hit(slots[gi], id_rt);
  end

  assign rs_hit = id_valid && id_rs_used && (id_rs != 5'd0) && (|rs_match);
  assign rt_hit = id_valid && id_rt_used && (id_rt != 5'd0) && (|rt_match);

  // rs has priority when both operands collide.
  assign pause_code = rs_hit ? PAUSE_RS : (rt_hit ? PAUSE_RT : PAUSE_NO);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slots <= '0;
    end else begin
      case (sb_op)
        SB_BUBBLE: begin
          slots[1] <= slots[0];
          slots[0] <= '0;
        end
        SB_ADVANCE: begin
          slots[1] <= slots[0];
          slots[0] <= incoming;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush controller: data-hazard stalls, data-memory freeze,
// stall counting and memory timeout. Optional PIPE_DELAY_SLOT_EN disables redirect flush.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic             id_reg_we,
  input  logic [4:0]       id_wreg,
  input  logic             id_redirect,
  input  logic             mem_access,
  input  logic             dmem_ready,
  output logic [1:0]       pause_code,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             mem_err
);

  localparam int WCNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(MEM_TIMEOUT);

  stall_state_t      state_reg, state_next;
  logic [WCNT_W-1:0] wcnt_reg, wcnt_next;
  logic              mem_err_reg, mem_err_next;
  logic [CNT_W-1:0]  stall_cnt_reg;
  sb_op_t            sb_op;
  logic              freeze;
  logic              haz;
  logic              redirect_flush;

  hazard_scoreboard u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .sb_op      (sb_op),
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_rs_used (id_rs_used),
    .id_rt_used (id_rt_used),
    .id_reg_we  (id_reg_we),
    .id_wreg    (id_wreg),
    .pause_code (pause_code)
  );

  assign freeze = mem_access && !dmem_ready;
  assign haz    = (pause_code != PAUSE_NO);

`ifdef PIPE_DELAY_SLOT_EN
  assign redirect_flush = 1'b0;
`else
  assign redirect_flush = id_redirect;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= STALL_RUN;
      wcnt_reg      <= '0;
      mem_err_reg   <= 1'b0;
      stall_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      wcnt_reg    <= wcnt_next;
      mem_err_reg <= mem_err_next;
      if (!pc_en && (stall_cnt_reg != {CNT_W{1'b1}}))
        stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
    end
  end

  always_comb begin
    state_next   = state_reg;
    wcnt_next    = wcnt_reg;
    mem_err_next = mem_err_reg;
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    idex_en      = 1'b1;
    exmem_en     = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    memwb_flush  = 1'b0;
    sb_op        = SB_ADVANCE;

    case (state_reg)
      STALL_RUN: begin
        if (freeze) begin
          state_next = STALL_MEM_WAIT;
          wcnt_next  = '0;
        end
      end
      STALL_MEM_WAIT: begin
        if (dmem_ready) begin
          state_next = STALL_RUN;
        end else begin
          // Counter parks at the limit; the error flag is sticky until reset.
          if (wcnt_reg != WCNT_MAX)
            wcnt_next = wcnt_reg + WCNT_W'(1);
          if (wcnt_next == WCNT_MAX)
            mem_err_next = 1'b1;
        end
      end
      default: state_next = STALL_RUN;
    endcase

    if (freeze) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_flush = 1'b1;
      sb_op       = SB_HOLD;
    end else if (haz) begin
      // Redirect is deferred until the dependent instruction leaves ID.
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
      sb_op      = SB_BUBBLE;
    end else begin
      ifid_flush = redirect_flush;
    end
  end

  assign stall_cnt = stall_cnt_reg;
  assign mem_err   = mem_err_reg;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: directed vector table, multi-cycle
// corner sequences (timeout, reset) and randomized cycles against a reference model.
module tb_pipe_stall_ctrl;

`ifdef PIPE_DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid, id_rs_used, id_rt_used, id_reg_we, id_redirect;
  logic [4:0]  id_rs, id_rt, id_wreg;
  logic        mem_access, dmem_ready;
  logic [1:0]  pause_code;
  logic        pc_en, ifid_en, idex_en, exmem_en;
  logic        ifid_flush, idex_flush, memwb_flush;
  logic [31:0] stall_cnt;
  logic        mem_err;

  int total = 0;
  int bad   = 0;

  pipe_stall_ctrl #(.CNT_W(32), .MEM_TIMEOUT(255)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_reg_we(id_reg_we), .id_wreg(id_wreg), .id_redirect(id_redirect),
    .mem_access(mem_access), .dmem_ready(dmem_ready),
    .pause_code(pause_code), .pc_en(pc_en), .ifid_en(ifid_en),
    .idex_en(idex_en), .exmem_en(exmem_en), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .memwb_flush(memwb_flush),
    .stall_cnt(stall_cnt), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [4:0] rs, rt;
    logic       rsu, rtu, we;
    logic [4:0] wreg;
    logic       redir, macc, rdy;
    logic [1:0] pause;
    logic [3:0] en;   // {pc, ifid, idex, exmem}
    logic [2:0] fl;   // {ifid, idex, memwb}
    int         stall;
  } vec_t;

  localparam logic [3:0] EN_RUN = 4'b1111, EN_HAZ = 4'b0011, EN_FRZ = 4'b0000;
  localparam logic [2:0] FL_RUN = 3'b000, FL_HAZ = 3'b010, FL_FRZ = 3'b001;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic rsu, input logic rtu, input logic we,
                       input logic [4:0] wreg, input logic redir,
                       input logic macc, input logic rdy);
    id_valid = v; id_rs = rs; id_rt = rt; id_rs_used = rsu; id_rt_used = rtu;
    id_reg_we = we; id_wreg = wreg; id_redirect = redir;
    mem_access = macc; dmem_ready = rdy;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic check_outs(input string tag, input logic [1:0] p, input logic [3:0] en,
                            input logic [2:0] fl, input int st);
    check({tag, ".pause"}, 64'(pause_code), 64'(p));
    check({tag, ".en"}, 64'({pc_en, ifid_en, idex_en, exmem_en}), 64'(en));
    check({tag, ".flush"}, 64'({ifid_flush, idex_flush, memwb_flush}), 64'(fl));
    check({tag, ".stall_cnt"}, 64'(stall_cnt), 64'(st));
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  vec_t vecs[$];

  function automatic vec_t mk(logic v, logic [4:0] rs, logic [4:0] rt, logic rsu, logic rtu,
                              logic we, logic [4:0] wreg, logic redir, logic macc, logic rdy,
                              logic [1:0] p, logic [3:0] en, logic [2:0] fl, int st);
    vec_t r;
    r.v = v; r.rs = rs; r.rt = rt; r.rsu = rsu; r.rtu = rtu; r.we = we; r.wreg = wreg;
    r.redir = redir; r.macc = macc; r.rdy = rdy;
    r.pause = p; r.en = en; r.fl = fl; r.stall = st;
    return r;
  endfunction

  // Reference model: age-ordered list of in-flight writers (index 0 = youngest, in EX).
  int          pend[$];
  bit          m_wait;
  int          m_wcnt;
  bit          m_err;
  longint      m_stall;

  initial begin
    logic [1:0] e_pause;
    logic [3:0] e_en;
    logic [2:0] e_fl;
    bit         rsh, rth, frz;
    vec_t       t;

    // addu $3,$1,$2 ; addu $4,$3,$3 (2 stalls)
    vecs.push_back(mk(1, 1, 2, 1, 1, 1, 3, 0, 0, 1, 2'b00, EN_RUN, FL_RUN, 0));
    vecs.push_back(mk(1, 3, 3, 1, 1, 1, 4, 0, 0, 1, 2'b01, EN_HAZ, FL_HAZ, 0));
    vecs.push_back(mk(1, 3, 3, 1, 1, 1, 4, 0, 0, 1, 2'b01, EN_HAZ, FL_HAZ, 1));
    vecs.push_back(mk(1, 3, 3, 1, 1, 1, 4, 0, 0, 1, 2'b00, EN_RUN, FL_RUN, 2));
    // lw $5,0($0) ; sll $6,$5,2 (rt only)
    vecs.push_back(mk(1, 0, 5, 1, 0, 1, 5, 0, 0, 1, 2'b00, EN_RUN, FL_RUN, 2));
    vecs.push_back(mk(1, 0, 5, 0, 1, 1, 6, 0, 0, 1, 2'b10, EN_HAZ, FL_HAZ, 2));
    vecs.push_back(mk(1, 0, 5, 0, 1, 1, 6, 0, 0, 1, 2'b10, EN_HAZ, FL_HAZ, 3));
    vecs.push_back(mk(1, 0, 5, 0, 1, 1, 6, 0, 0, 1, 2'b00, EN_RUN, FL_RUN, 4));
    // write to $0, then reads of $0 never stall
    vecs.push_back(mk(1, 1, 2, 1, 1, 1, 0, 0, 0, 1, 2'b00, EN_RUN, FL_RUN, 4));
    vecs.push_back(mk(1, 0, 0, 1, 1, 0, 0, 0, 0, 1, 2'b00, EN_RUN, FL_RUN, 4));
    // sw in MEM, dmem_ready low for 3 cycles
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, EN_FRZ, FL_FRZ, 4));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, EN_FRZ, FL_FRZ, 5));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, EN_FRZ, FL_FRZ, 6));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2'b00, EN_RUN, FL_RUN, 7));
    // freeze over hazard, then hazard + redirect, redirect taken once ID advances
    vecs.push_back(mk(1, 1, 2, 1, 1, 1, 8, 0, 0, 1, 2'b00, EN_RUN, FL_RUN, 7));
    vecs.push_back(mk(1, 8, 0, 1, 0, 0, 0, 1, 1, 0, 2'b01, EN_FRZ, FL_FRZ, 7));
    vecs.push_back(mk(1, 8, 0, 1, 0, 0, 0, 1, 0, 1, 2'b01, EN_HAZ, FL_HAZ, 8));
    vecs.push_back(mk(1, 8, 0, 1, 0, 0, 0, 1, 0, 1, 2'b01, EN_HAZ, FL_HAZ, 9));
    vecs.push_back(mk(1, 8, 0, 1, 0, 0, 0, 1, 0, 1, 2'b00, EN_RUN, DS ? FL_RUN : 3'b100, 10));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, EN_RUN, FL_RUN, 10));

    // ---- reset state ----
    idle();
    #3;
    check_outs("reset", 2'b00, EN_RUN, FL_RUN, 0);
    check("reset.mem_err", 64'(mem_err), 64'd0);
    @(posedge clk);
    #2 rst = 1'b0;

    // ---- directed table ----
    for (int i = 0; i < vecs.size(); i++) begin
      t = vecs[i];
      drive(t.v, t.rs, t.rt, t.rsu, t.rtu, t.we, t.wreg, t.redir, t.macc, t.rdy);
      #1;
      $display("vec %0d: pause=%b en=%b fl=%b stall=%0d", i, pause_code,
               {pc_en, ifid_en, idex_en, exmem_en}, {ifid_flush, idex_flush, memwb_flush}, stall_cnt);
      check_outs($sformatf("vec%0d", i), t.pause, t.en, t.fl, t.stall);
      @(posedge clk);
      #2;
    end

    // ---- memory timeout: 256 cycles low sets mem_err, sticky ----
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    repeat (255) @(posedge clk);
    #3 check("timeout.before", 64'(mem_err), 64'd0);
    @(posedge clk);
    #3 check("timeout.set", 64'(mem_err), 64'd1);
    check("timeout.stall_cnt", 64'(stall_cnt), 64'd256);
    repeat (5) @(posedge clk);
    #2 dmem_ready = 1'b1;
    @(posedge clk);
    #2 idle();
    repeat (3) @(posedge clk);
    #3 check("timeout.sticky", 64'(mem_err), 64'd1);
    check("timeout.stall_hold", 64'(stall_cnt), 64'd261);
    $display("timeout seq: mem_err=%b stall=%0d", mem_err, stall_cnt);
    rst = 1'b1;
    #1 check("timeout.rst_clear", 64'(mem_err), 64'd0);
    @(posedge clk);
    #2 rst = 1'b0;

    // ---- reset pulse during MEM_WAIT with a hazard pending ----
    drive(1, 1, 2, 1, 1, 1, 9, 0, 0, 1);
    @(posedge clk);
    #2 drive(1, 9, 0, 1, 0, 0, 0, 0, 1, 0);
    @(posedge clk);
    #2 check("rstwait.pre_pause", 64'(pause_code), 64'd1);
    check("rstwait.pre_stall", 64'(stall_cnt), 64'd1);
    rst = 1'b1;
    mem_access = 1'b0;
    #1 check_outs("rstwait", 2'b00, EN_RUN, FL_RUN, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check("rstwait.sb_empty", 64'(pause_code), 64'd0);
    $display("reset seq: pause=%b stall=%0d", pause_code, stall_cnt);

    // ---- randomized cycles against the reference model ----
    do_reset();
    pend = '{-1, -1};
    m_wait = 0; m_wcnt = 0; m_err = 0; m_stall = 0;
    for (int c = 0; c < 400; c++) begin
      drive(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0), 1'($urandom));
      rsh = 0; rth = 0;
      foreach (pend[k]) begin
        if (pend[k] >= 0 && pend[k] == int'(id_rs)) rsh = 1;
        if (pend[k] >= 0 && pend[k] == int'(id_rt)) rth = 1;
      end
      rsh = rsh && id_valid && id_rs_used && id_rs != 0;
      rth = rth && id_valid && id_rt_used && id_rt != 0;
      e_pause = rsh ? 2'b01 : (rth ? 2'b10 : 2'b00);
      frz = mem_access && !dmem_ready;
      if (frz)             begin e_en = EN_FRZ; e_fl = FL_FRZ; end
      else if (e_pause != 0) begin e_en = EN_HAZ; e_fl = FL_HAZ; end
      else                 begin e_en = EN_RUN; e_fl = {id_redirect && !DS, 2'b00}; end
      #1;
      $display("rnd %0d: pause=%b en=%b fl=%b stall=%0d", c, pause_code,
               {pc_en, ifid_en, idex_en, exmem_en}, {ifid_flush, idex_flush, memwb_flush}, stall_cnt);
      check_outs($sformatf("rnd%0d", c), e_pause, e_en, e_fl, int'(m_stall));
      check($sformatf("rnd%0d.mem_err", c), 64'(mem_err), 64'(m_err));
      // advance the model across the coming edge
      if (!frz) begin
        if (e_pause != 0) pend.push_front(-1);
        else pend.push_front((id_valid && id_reg_we && id_wreg != 0) ? int'(id_wreg) : -1);
        void'(pend.pop_back());
      end
      if (e_en[3] == 1'b0 && m_stall < 64'hFFFF_FFFF) m_stall++;
      if (!m_wait) begin
        if (frz) begin m_wait = 1; m_wcnt = 0; end
      end else if (dmem_ready) m_wait = 0;
      else begin
        if (m_wcnt < 255) m_wcnt++;
        if (m_wcnt == 255) m_err = 1;
      end
      @(posedge clk);
      #2;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
# pipe_stall_ctrl

Central stall/flush controller for the 5-stage MIPS pipeline. Tracks in-flight register writes in EX and MEM (no forwarding path) and produces the `pause_in` hazard code consumed by `control_unit`. Drives every pipeline-register enable and flush, freezes the pipe while data memory is busy, and counts stall cycles.

## Interface
- `CNT_W`, 32: stall counter width.
- `MEM_TIMEOUT`, 255: maximum MEM_WAIT cycles before `mem_err` is set.
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `id_valid`  in  1: ID holds a real instruction.
- `id_rs`, `id_rt`  in  5: source register numbers in ID.
- `id_rs_used`, `id_rt_used`  in  1: ID instruction reads rs / rt.
- `id_reg_we`  in  1: ID instruction writes the register file (`RegWE`).
- `id_wreg`  in  5: final destination register, after the `WriteRegSrc` mux.
- `id_redirect`  in  1: `PCsrc != PFU_OP_NEXT` in ID.
- `mem_access`  in  1: MEM-stage instruction is `lw`/`sw`.
- `dmem_ready`  in  1: data memory completes the access this cycle.
- `pause_code`  out  2: to `control_unit` `pause_in`.
- `pc_en`, `ifid_en`, `idex_en`, `exmem_en`  out  1: register enables.
- `ifid_flush`, `idex_flush`, `memwb_flush`  out  1: load a bubble.
- `stall_cnt`  out  CNT_W: cycles with `pc_en=0`.
- `mem_err`  out  1: sticky memory-timeout flag.

## Operation
- Scoreboard has two slots, SB_EX and SB_MEM, each holding {valid, wreg}. A slot is valid only when `reg_we=1` and `wreg!=0`.
- Hit detection:
  - rs_hit = `id_valid & id_rs_used & id_rs!=0 &` (match on any valid slot).
  - rt_hit: same with rt.
- `pause_code` encoding:
  - PAUSE_NO = 00 when there is no hit.
  - Only rs used: PAUSE_RS = 01 on rs_hit.
  - Only rt used: PAUSE_RT = 10 on rt_hit.
  - Both used: PAUSE_RS on rs_hit, else PAUSE_RT on rt_hit.
- haz = `pause_code != PAUSE_NO`.
- FSM states:
  - RUN → MEM_WAIT when `mem_access & !dmem_ready`.
  - MEM_WAIT → RUN when `dmem_ready`.
  - MEM_WAIT holds a wait counter `wcnt`, cleared on entry.
  - When `wcnt` reaches `MEM_TIMEOUT`: set `mem_err`, stay in MEM_WAIT.
- Freeze condition: `mem_access & !dmem_ready`, combinational in either state.
- Outputs per priority, highest first:
  - Freeze: all enables 0, `idex_flush=0`, `memwb_flush=1`. Scoreboard holds.
  - haz: `pc_en=ifid_en=0`, `idex_flush=1`, `exmem_en=1`. SB_MEM ← SB_EX, SB_EX ← invalid.
  - Normal: all enables 1. SB_MEM ← SB_EX, SB_EX ← ID write info.
- While haz is active, `id_redirect` is ignored. It is evaluated again once ID advances.
- `stall_cnt` increments on every cycle with `pc_en=0` and saturates at all-ones.

## Timing
- Reset values:
  - FSM = RUN, scoreboard invalid, `wcnt=0`, `stall_cnt=0`, `mem_err=0`.
  - Outputs settle combinationally: all enables 1, all flushes 0, `pause_code=00`.
- `pause_code`, the enables and the flushes are combinational from the scoreboard and the ID/MEM inputs. There is no added latency.
- Scoreboard, FSM, counters and `mem_err` update at the rising edge.
- Back-to-back dependency with the producer in EX: 2 stall cycles, then issue.
- Dependency with the producer in MEM: 1 stall cycle.
- `dmem_ready` already high in the first MEM cycle: no freeze, FSM stays in RUN.
- `dmem_ready` rises while in MEM_WAIT: the pipe advances in that same cycle.
- `mem_err` is cleared only by `rst`.
- `rst` asserted mid-stall or mid-MEM_WAIT aborts immediately to the reset state.

## Configuration
- `PIPE_DELAY_SLOT_EN` defined: branch delay slot. `id_redirect` never flushes, so `ifid_flush=0` always.
- Undefined: `id_redirect` in a normal (non-haz, non-freeze) cycle sets `ifid_flush=1`, discarding the fetched instruction.

## Structure
- Shared package `const.vh` holds:
  - `PAUSE_NO`, `PAUSE_RS`, `PAUSE_RT` (2-bit).
  - FSM state encodings `STALL_RUN`, `STALL_MEM_WAIT`.
- One sub-module, `hazard_scoreboard`: the two slots, plus hit detection and `pause_code` generation.
- FSM, enables and counters stay in the top module.

## Test plan
- `addu $3,$1,$2` then `addu $4,$3,$3`:
  - 2 cycles of `pause_code=01`, `pc_en=0`, `idex_flush=1`.
  - Third cycle `pause_code=00`.
  - `stall_cnt=2`.
- `lw $5,0($0)` then `sll $6,$5,2` (rt only):
  - `pause_code=10` for 2 cycles.
  - Writes to `$0` never stall.
- `sw` in MEM with `dmem_ready` low for 3 cycles:
  - All enables 0 and `memwb_flush=1` for 3 cycles; FSM returns to RUN on the 4th.
  - `stall_cnt=3`.
- Hazard and `id_redirect` in the same cycle:
  - Stall first.
  - After the stall clears (macro undefined), `ifid_flush=1` for exactly 1 cycle.
- `dmem_ready` held low for 256 cycles: `mem_err=1` sticky, cleared only by `rst`.
- `rst` pulse during MEM_WAIT: FSM = RUN, scoreboard empty and `stall_cnt=0` within the same cycle.
